// File: rtl/bus_transfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl_pkg
// Description : Shared definitions for the bus-register transfer sequencer:
//               state encodings, bus-select encodings and a legality helper.
//               Also imported by the register-bank top level and the bench.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_transfer_ctrl_pkg;

    // Sequencer states, fixed encodings shared with the bank top level
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Bus-select encodings carried on req_bus
    localparam logic c_BUS1 = 1'b0;
    localparam logic c_BUS2 = 1'b1;

    // A transfer is legal when both indices exist and differ; a register
    // can never drive the bus it is loading from
    function automatic logic req_is_legal(input int src, input int dst, input int nregs);
        return (src != dst) && (src < nregs) && (dst < nregs);
    endfunction

endpackage : bus_transfer_ctrl_pkg
`default_nettype wire

// File: rtl/bus_transfer_ctrl_onehot.sv
`default_nettype none
// ============================================================================
// Module      : onehot_decoder
// Description : Index-to-one-hot decoder with enable. Output is all zero when
//               disabled or when the index is beyond OUT_N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_decoder #(
    parameter int IN_W  = 3,
    parameter int OUT_N = 8
) (
    input  logic [IN_W-1:0]  i_idx,
    input  logic             i_en,
    output logic [OUT_N-1:0] o_vec
);

    // Compare the index against every output position
    always_comb begin
        o_vec = '0;
        for (int i = 0; i < OUT_N; i++) begin
            o_vec[i] = i_en && (i_idx == IN_W'(i));
        end
    end

endmodule : onehot_decoder
`default_nettype wire

// File: rtl/bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_transfer_ctrl
// Description : Sequencer for a bank of dual-output bus registers. Accepts a
//               register-to-register transfer request, drives the source
//               output enable on the selected bus for two cycles and pulses
//               the destination load in the second. An IDLE cycle between
//               transfers gives break-before-make on the shared buses.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transfer_ctrl
    import bus_transfer_ctrl_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IDXW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDXW-1:0]  req_src,
    input  logic [IDXW-1:0]  req_dst,
    input  logic             req_bus,
    output logic [NREGS-1:0] en1,
    output logic [NREGS-1:0] en2,
    output logic [NREGS-1:0] load,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_src;
    logic [IDXW-1:0]   r_dst;
    logic              r_bus;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_legal;
    logic              w_drive_phase;

    // Acceptance depends on state only, so req_ready has no input path
    assign w_accept = req_valid && (r_state == ST_IDLE);
    assign w_legal  = req_is_legal(int'(req_src), int'(req_dst), NREGS);

    // State register, captured request fields and the completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_bus   <= c_BUS1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_LATCH);
            r_err   <= (r_state == ST_FAULT);
            if (w_accept) begin
                r_src <= req_src;
                r_dst <= req_dst;
                r_bus <= req_bus;
            end
        end
    end

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_legal ? ST_DRIVE : ST_FAULT;
                end
            end
            ST_DRIVE: w_state_next = ST_LATCH;
            ST_LATCH: w_state_next = ST_IDLE;
            ST_FAULT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Source enable stays on through DRIVE and LATCH so the bus is settled
    // for the whole cycle in which the destination captures it
    assign w_drive_phase = (r_state == ST_DRIVE) || (r_state == ST_LATCH);

    onehot_decoder #(
        .IN_W  (IDXW),
        .OUT_N (NREGS)
    ) u_dec_en1 (
        .i_idx (r_src),
        .i_en  (w_drive_phase && (r_bus == c_BUS1)),
        .o_vec (en1)
    );

    onehot_decoder #(
        .IN_W  (IDXW),
        .OUT_N (NREGS)
    ) u_dec_en2 (
        .i_idx (r_src),
        .i_en  (w_drive_phase && (r_bus == c_BUS2)),
        .o_vec (en2)
    );

    onehot_decoder #(
        .IN_W  (IDXW),
        .OUT_N (NREGS)
    ) u_dec_load (
        .i_idx (r_dst),
        .i_en  (r_state == ST_LATCH),
        .o_vec (load)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule : bus_transfer_ctrl
`default_nettype wire

// File: tb/tb_bus_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transfer_ctrl
// Description : Scoreboard bench for bus_transfer_ctrl. A timeline model
//               pushes the expected strobe/pulse activity for each accepted
//               request; a negedge monitor compares every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transfer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_src = '0;
    logic [2:0] req_dst = '0;
    logic       req_bus = 1'b0;
    logic [7:0] en1, en2, load;
    logic       busy, done, err;

    // Second instance with a non-power-of-two register count
    logic       v6 = 1'b0;
    logic       rdy6;
    logic [2:0] s6 = '0;
    logic [2:0] d6 = '0;
    logic       b6 = 1'b0;
    logic [5:0] e16, e26, l6;
    logic       busy6, done6, err6;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_transfer_ctrl #(.NREGS(8), .IDXW(3)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_bus(req_bus),
        .en1(en1), .en2(en2), .load(load), .busy(busy), .done(done), .err(err)
    );

    bus_transfer_ctrl #(.NREGS(6), .IDXW(3)) dut6 (
        .clk(clk), .rst(rst), .req_valid(v6), .req_ready(rdy6),
        .req_src(s6), .req_dst(d6), .req_bus(b6),
        .en1(e16), .en2(e26), .load(l6), .busy(busy6), .done(done6), .err(err6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference timeline model ----------------
    typedef struct {
        int         cyc;
        logic [7:0] en1;
        logic [7:0] en2;
        logic [7:0] load;
        logic       done;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   free_at  = 0;     // first cycle in which the controller is idle again
    int   last_acc = -1;    // edge number of the most recent acceptance
    bit   chk_en   = 1'b0;

    // After edge e the DUT shows cycle e. A legal request accepted at edge e
    // drives in cycles e and e+1, loads in e+1 and reports done in e+2.
    always @(posedge clk) begin
        int   e;
        exp_t r;
        logic [7:0] sv, dv;
        edge_cnt++;
        e = edge_cnt;
        if (rst) begin
            q.delete();
            free_at = e;
        end else if (req_valid && (e - 1) >= free_at) begin
            last_acc = e;
            sv = 8'd1 << req_src;
            dv = 8'd1 << req_dst;
            if (req_src != req_dst) begin
                r = '{cyc: e, en1: (req_bus ? 8'd0 : sv), en2: (req_bus ? sv : 8'd0),
                      load: 8'd0, done: 1'b0, err: 1'b0};
                q.push_back(r);
                r.cyc  = e + 1;
                r.load = dv;
                q.push_back(r);
                r = '{cyc: e + 2, en1: 8'd0, en2: 8'd0, load: 8'd0, done: 1'b1, err: 1'b0};
                q.push_back(r);
                free_at = e + 2;
            end else begin
                r = '{cyc: e + 1, en1: 8'd0, en2: 8'd0, load: 8'd0, done: 1'b0, err: 1'b1};
                q.push_back(r);
                free_at = e + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int   c;
        exp_t x;
        logic b;
        if (chk_en) begin
            c = edge_cnt;
            while (q.size() > 0 && q[0].cyc < c) begin
                x = q.pop_front();
                chk("missed_event_cycle", 32'(c), 32'(x.cyc));
            end
            x = '{cyc: c, en1: 8'd0, en2: 8'd0, load: 8'd0, done: 1'b0, err: 1'b0};
            if (q.size() > 0 && q[0].cyc == c) x = q.pop_front();
            b = (c < free_at);
            chk("en1", 32'(en1), 32'(x.en1));
            chk("en2", 32'(en2), 32'(x.en2));
            chk("load", 32'(load), 32'(x.load));
            chk("done", 32'(done), 32'(x.done));
            chk("err", 32'(err), 32'(x.err));
            chk("busy", 32'(busy), 32'(b));
            chk("req_ready", 32'(req_ready), 32'(!b));
            chk("inv_en1_onehot", 32'($countones(en1) <= 1), 32'd1);
            chk("inv_en2_onehot", 32'($countones(en2) <= 1), 32'd1);
            chk("inv_bus_contention", 32'((en1 != 0) && (en2 != 0)), 32'd0);
            chk("inv_load_onehot", 32'($countones(load) <= 1), 32'd1);
            chk("inv_load_vs_enable", 32'(load & (en1 | en2)), 32'd0);
            chk("inv_done_err", 32'(done && err), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int s, input int d, input int b);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_src   = 3'(s);
        req_dst   = 3'(d);
        req_bus   = 1'(b);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (last_acc == edge_cnt) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        chk("handshake_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // idle after reset
        repeat (5) @(negedge clk);

        // basic transfer 2 -> 5 on bus 1
        send(2, 5, 0);
        repeat (4) @(negedge clk);

        // back-to-back with valid held: 1->3 bus 1, then 3->6 bus 2
        send(1, 3, 0);
        send(3, 6, 1);
        repeat (4) @(negedge clk);

        // rejected: src == dst
        send(4, 4, 0);
        repeat (3) @(negedge clk);

        // reset during LATCH of 0 -> 1: no load afterwards, no done
        send(0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // NREGS=6 instance: dst=7 out of range -> err two cycles after accept
        v6 = 1'b1; s6 = 3'd1; d6 = 3'd7; b6 = 1'b0;
        @(negedge clk);
        v6 = 1'b0;
        chk("n6_fault_busy", 32'(busy6), 32'd1);
        chk("n6_fault_strobes", 32'({e16, e26, l6}), 32'd0);
        @(negedge clk);
        chk("n6_err", 32'(err6), 32'd1);
        chk("n6_err_ready", 32'(rdy6), 32'd1);
        chk("n6_err_no_done", 32'(done6), 32'd0);
        @(negedge clk);
        chk("n6_err_single", 32'(err6), 32'd0);

        // NREGS=6 instance: legal 1 -> 5 on bus 2
        v6 = 1'b1; s6 = 3'd1; d6 = 3'd5; b6 = 1'b1;
        @(negedge clk);
        v6 = 1'b0;
        chk("n6_drive_en2", 32'(e26), 32'h02);
        chk("n6_drive_en1", 32'(e16), 32'h00);
        chk("n6_drive_load", 32'(l6), 32'h00);
        @(negedge clk);
        chk("n6_latch_en2", 32'(e26), 32'h02);
        chk("n6_latch_load", 32'(l6), 32'h20);
        @(negedge clk);
        chk("n6_done", 32'(done6), 32'd1);
        chk("n6_done_strobes", 32'({e16, e26, l6}), 32'd0);

        // randomized traffic with occasional resets; inputs keep changing
        // while busy and must be ignored
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            req_valid = 1'($urandom_range(0, 1));
            req_src   = 3'($urandom_range(0, 7));
            req_dst   = ($urandom_range(0, 7) == 0) ? req_src : 3'($urandom_range(0, 7));
            req_bus   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_bus_transfer_ctrl
`default_nettype wire
